dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-master arbiter that shares the single-port data memory / peripheral space between the CPU pipeline's MEM stage and a DMA/loader master (UART bootloader, debug reader). It sits directly in front of the data memory. The CPU has fixed priority, with a starvation counter that guarantees the DMA master one slot after a bounded wait. It also routes the memory's one-cycle-registered read data back to whichever master issued the read.

## Interface
Parameters:
- ADDR_W, 32, address width (byte address; bits [31:28]==4'h4 select peripheral space, passed through untouched)
- DATA_W, 32, data width
- STARVE_LIMIT, 8, consecutive denied DMA cycles before a forced DMA slot (legal 1..255)

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_read  in  1  CPU MEM-stage read request
- cpu_write  in  1  CPU MEM-stage write request
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_stall  out  1  CPU must hold its MEM-stage request this cycle
- cpu_rdata  out  DATA_W  read data for the CPU read granted in the previous cycle
- dma_req  in  1  DMA request valid; held until dma_gnt
- dma_we  in  1  1 = write, 0 = read
- dma_addr  in  ADDR_W  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_gnt  out  1  DMA request accepted this cycle
- dma_rvalid  out  1  dma_rdata valid (one cycle after a granted DMA read)
- dma_rdata  out  DATA_W  DMA read data
- mem_addr  out  ADDR_W  to memory Address
- mem_wdata  out  DATA_W  to memory Write_data
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_rdata  in  DATA_W  from memory Read_data (registered in memory, 1-cycle latency)

## Operation
- cpu_act = cpu_read | cpu_write. If both are asserted, write wins at the memory and the read also returns data.
- Arbitration is combinational each cycle:
  - force = (starve_cnt == STARVE_LIMIT) & dma_req.
  - dma_gnt = dma_req & (force | ~cpu_act).
  - cpu_stall = cpu_act & dma_gnt.
- Memory mux:
  - DMA granted: mem_addr = dma_addr, mem_wdata = dma_wdata, mem_write = dma_we, mem_read = ~dma_we.
  - Otherwise: mem_addr = cpu_addr, mem_wdata = cpu_wdata, mem_read = cpu_read, mem_write = cpu_write.
  - With no requester, mem_read and mem_write are 0 and the address follows cpu_addr.
- starve_cnt (8-bit):
  - Cleared on reset, on dma_gnt, or when dma_req = 0.
  - Incremented when dma_req & ~dma_gnt.
  - Saturates at STARVE_LIMIT.
- Return path: register rd_owner ∈ {NONE, CPU, DMA}, set from the granted read each cycle.
  - dma_rvalid = (rd_owner == DMA); dma_rdata = mem_rdata.
  - cpu_rdata = mem_rdata when rd_owner == CPU, else 0.
- Peripheral side effects (e.g. clearing done flags by write) are caused only by the granted master's write. A stalled CPU write never reaches the memory.

## Timing
- Reset values: rd_owner = NONE, starve_cnt = 0. While reset is high, every output is 0 regardless of inputs: cpu_stall, dma_gnt, dma_rvalid, mem_read, mem_write, cpu_rdata, dma_rdata, mem_addr, mem_wdata.
- Grant, stall and mem_* are same-cycle combinational from requests.
- Read data returns exactly 1 cycle after grant.
- Back-to-back grants to alternating masters are legal. rd_owner pipelines one deep, so no bubble is needed.
- With STARVE_LIMIT = N and continuous CPU traffic, a DMA request asserted at cycle t is granted at cycle t+N. The counter reaches N at t+N and force takes effect in that cycle.
- After a forced grant the counter is 0. A still-pending next DMA request waits another N cycles.
- dma_req dropped before grant: the counter clears with no grant. This is legal but discouraged.
- Reset asserted mid-read: the pending dma_rvalid/cpu_rdata is discarded. There is no return after reset release.

## Structure
- Package dmem_arb_pkg holds:
  - the owner enum (NONE = 2'd0, CPU = 2'd1, DMA = 2'd2)
  - the STARVE_LIMIT default
  - the peripheral-space decode constant 4'h4
- One sub-module, arb_starve_cnt: saturating counter with clear/inc/limit and a `at_limit` output.
- The mux, grant logic and return register stay in the top.

## Test plan
- CPU-only reads to 0x0, 0x4 with memory preloaded 0x11, 0x22: mem_read = 1 each cycle, cpu_stall = 0; cpu_rdata = 0x11 then 0x22 one cycle later; dma_* stay 0.
- DMA write 0xDEADBEEF to 0x10 with CPU idle: dma_gnt in the same cycle, mem_write = 1, mem_addr = 0x10. A following DMA read of 0x10 gives dma_rvalid one cycle later with dma_rdata = 0xDEADBEEF.
- STARVE_LIMIT = 8, CPU requesting every cycle, DMA read pending from cycle 0:
  - dma_gnt and cpu_stall high only at cycle 8.
  - CPU request reissued at cycle 9 succeeds.
  - dma_rvalid at cycle 9.
- Same-cycle CPU write to 0x20 and forced DMA write to 0x20 (0xAAAA / 0x5555): memory holds the DMA value. The CPU write lands the next cycle, giving a final value of 0xAAAA.
- Alternating granted reads (CPU at t, DMA at t+1, CPU at t+2): rd_owner routes each return correctly with no data crossover.
- Reset asserted one cycle after a granted DMA read: dma_rvalid = 0 and all outputs 0 during reset; starve_cnt = 0 after release.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: read-return owner
// encoding, default starvation bound and the peripheral-space decode value.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPU  = 2'd1,
        DMA  = 2'd2
    } owner_e;

    localparam int STARVE_LIMIT_DEF = 8;

    // Address bits [31:28] equal to this select peripheral space; the arbiter
    // forwards such accesses unchanged.
    localparam logic [3:0] PERIPH_SEL = 4'h4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive cycles the DMA master has been refused;
// at_limit_o tells the arbiter to force the next DMA slot.
module arb_starve_cnt #(
    parameter int LIMIT = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_limit_o
);

    localparam logic [7:0] LIMIT_C = 8'(LIMIT);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/dmem_arbiter.sv
// CPU-priority arbiter in front of the single-port data memory, with a bounded
// wait for the DMA/loader master and routing of the registered read data.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic   cpu_act;
    logic   at_limit;
    logic   force_dma;
    logic   gnt;
    owner_e rd_owner_q;
    owner_e rd_owner_d;

    arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk_i      (clk),
        .rst_i      (reset),
        .clr_i      (gnt | ~dma_req),
        .inc_i      (dma_req & ~gnt),
        .at_limit_o (at_limit)
    );

    assign cpu_act   = cpu_read | cpu_write;
    assign force_dma = at_limit & dma_req;
    assign gnt       = dma_req & (force_dma | ~cpu_act) & ~reset;
    assign dma_gnt   = gnt;
    assign cpu_stall = cpu_act & gnt;

    // A stalled CPU write is fully replaced by the DMA access, so it never
    // reaches memory or a peripheral.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (reset) begin
            mem_addr = '0;
        end else if (gnt) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_write = dma_we;
            mem_read  = ~dma_we;
        end else begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_read  = cpu_read;
            mem_write = cpu_write;
        end
    end

    always_comb begin
        rd_owner_d = NONE;
        if (gnt && !dma_we) begin
            rd_owner_d = DMA;
        end else if (cpu_read && !gnt) begin
            rd_owner_d = CPU;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_owner_q <= NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    assign dma_rvalid = (rd_owner_q == DMA) & ~reset;
    assign dma_rdata  = reset ? '0 : mem_rdata;
    assign cpu_rdata  = ((rd_owner_q == CPU) && !reset) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table of per-cycle vectors with a read-return
// scoreboard, then hand-written reset and starvation sequences.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk;
    logic        reset;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    dmem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_read   (cpu_read),
        .cpu_write  (cpu_write),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: registered read, one-cycle latency, preloaded on reset.
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < 64; j++) mem[j] <= 32'h0;
            mem[0] <= 32'h11;
            mem[1] <= 32'h22;
            mem_rdata <= 32'h0;
        end else begin
            if (mem_read) mem_rdata <= mem[mem_addr[7:2]];
            if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    typedef struct {
        logic        cr, cw;
        logic [31:0] ca, cwd;
        logic        dr, dw;
        logic [31:0] da, dwd;
        logic        g, s, mr, mw;
        logic [31:0] ma, mwd;
    } vec_t;

    typedef struct {
        logic [1:0]  own;
        logic [31:0] data;
    } ret_t;

    vec_t        tbl[$];
    ret_t        sb[$];
    logic [31:0] ref_mem [0:63];

    function automatic void add(input logic cr, input logic cw, input logic [31:0] ca,
                                input logic [31:0] cwd, input logic dr, input logic dw,
                                input logic [31:0] da, input logic [31:0] dwd,
                                input logic g, input logic s, input logic mr, input logic mw,
                                input logic [31:0] ma, input logic [31:0] mwd);
        vec_t v;
        v.cr = cr; v.cw = cw; v.ca = ca; v.cwd = cwd;
        v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
        v.g = g; v.s = s; v.mr = mr; v.mw = mw; v.ma = ma; v.mwd = mwd;
        tbl.push_back(v);
    endfunction

    function automatic void idle();
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_cpu_stall"}, {31'h0, cpu_stall}, 0);
        chk({tag, "_dma_gnt"}, {31'h0, dma_gnt}, 0);
        chk({tag, "_dma_rvalid"}, {31'h0, dma_rvalid}, 0);
        chk({tag, "_mem_read"}, {31'h0, mem_read}, 0);
        chk({tag, "_mem_write"}, {31'h0, mem_write}, 0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
        chk({tag, "_dma_rdata"}, dma_rdata, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    task automatic drive(input vec_t v);
        cpu_read = v.cr; cpu_write = v.cw; cpu_addr = v.ca; cpu_wdata = v.cwd;
        dma_req = v.dr; dma_we = v.dw; dma_addr = v.da; dma_wdata = v.dwd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        ret_t r;
        int   found;

        for (int j = 0; j < 64; j++) ref_mem[j] = 32'h0;
        ref_mem[0] = 32'h11;
        ref_mem[1] = 32'h22;

        // CPU-only reads, then idle with address following cpu_addr
        add(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0);
        add(1, 0, 32'h4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h4, 0);
        add(0, 0, 32'h30, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h30, 0);
        // DMA write then read-back with CPU idle
        add(0, 0, 0, 0, 1, 1, 32'h10, 32'hDEADBEEF, 1, 0, 0, 1, 32'h10, 32'hDEADBEEF);
        add(0, 0, 0, 0, 1, 0, 32'h10, 0, 1, 0, 1, 0, 32'h10, 0);
        idle();
        // Continuous CPU reads, DMA read pending: forced slot at cycle 8
        for (int k = 0; k < 8; k++) add(1, 0, 32'h4, 0, 1, 0, 32'h0, 0, 0, 0, 1, 0, 32'h4, 0);
        add(1, 0, 32'h4, 0, 1, 0, 32'h0, 0, 1, 1, 1, 0, 32'h0, 0);
        add(1, 0, 32'h4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h4, 0);
        idle();
        // CPU write 0xAAAA vs DMA write 0x5555 to 0x20; CPU lands after the forced slot
        for (int k = 0; k < 8; k++)
            add(0, 1, 32'h20, 32'hAAAA, 1, 1, 32'h20, 32'h5555, 0, 0, 0, 1, 32'h20, 32'hAAAA);
        add(0, 1, 32'h20, 32'hAAAA, 1, 1, 32'h20, 32'h5555, 1, 1, 0, 1, 32'h20, 32'h5555);
        add(0, 1, 32'h20, 32'hAAAA, 0, 0, 0, 0, 0, 0, 0, 1, 32'h20, 32'hAAAA);
        add(1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h20, 0);
        // Simultaneous CPU read+write: both strobes, read returns old data
        add(1, 1, 32'h24, 32'h77, 0, 0, 0, 0, 0, 0, 1, 1, 32'h24, 32'h77);
        add(1, 0, 32'h24, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h24, 0);
        // Alternating owners: CPU, DMA, CPU
        add(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0);
        add(0, 0, 0, 0, 1, 0, 32'h4, 0, 1, 0, 1, 0, 32'h4, 0);
        add(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h10, 0);
        idle();
        // DMA drops its request for one cycle: the wait restarts from zero
        for (int k = 0; k < 5; k++) add(1, 0, 32'h4, 0, 1, 0, 32'h0, 0, 0, 0, 1, 0, 32'h4, 0);
        add(1, 0, 32'h4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h4, 0);
        for (int k = 0; k < 8; k++) add(1, 0, 32'h4, 0, 1, 0, 32'h0, 0, 0, 0, 1, 0, 32'h4, 0);
        add(1, 0, 32'h4, 0, 1, 0, 32'h0, 0, 1, 1, 1, 0, 32'h0, 0);
        idle();
        idle();

        // Reset with active inputs: every output forced low
        reset = 1'b1;
        cpu_read = 1; cpu_write = 1; cpu_addr = 32'h44; cpu_wdata = 32'h1234;
        dma_req = 1; dma_we = 0; dma_addr = 32'h48; dma_wdata = 32'h5;
        #3;
        chk_zero("rst_init");
        @(posedge clk); #1;
        chk_zero("rst_init_edge");
        reset = 1'b0;
        r.own = NONE; r.data = 0;
        sb.push_back(r);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            drive(v);
            #3;
            chk($sformatf("v%0d_dma_gnt", i), {31'h0, dma_gnt}, {31'h0, v.g});
            chk($sformatf("v%0d_cpu_stall", i), {31'h0, cpu_stall}, {31'h0, v.s});
            chk($sformatf("v%0d_mem_read", i), {31'h0, mem_read}, {31'h0, v.mr});
            chk($sformatf("v%0d_mem_write", i), {31'h0, mem_write}, {31'h0, v.mw});
            chk($sformatf("v%0d_mem_addr", i), mem_addr, v.ma);
            if (v.mw) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, v.mwd);
            if (sb.size() == 0) begin
                chk($sformatf("v%0d_sb_empty", i), 32'd0, 32'd1);
            end else begin
                r = sb.pop_front();
                if (r.own == CPU) begin
                    chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, r.data);
                    chk($sformatf("v%0d_dma_rvalid", i), {31'h0, dma_rvalid}, 0);
                end else if (r.own == DMA) begin
                    chk($sformatf("v%0d_dma_rvalid", i), {31'h0, dma_rvalid}, 1);
                    chk($sformatf("v%0d_dma_rdata", i), dma_rdata, r.data);
                    chk($sformatf("v%0d_cpu_rdata_z", i), cpu_rdata, 0);
                end else begin
                    chk($sformatf("v%0d_dma_rvalid", i), {31'h0, dma_rvalid}, 0);
                    chk($sformatf("v%0d_cpu_rdata_z", i), cpu_rdata, 0);
                end
            end
            r.own  = (v.g && !v.dw) ? DMA : ((v.cr && !v.g) ? CPU : NONE);
            r.data = ref_mem[v.ma[7:2]];
            sb.push_back(r);
            if (v.mw) ref_mem[v.ma[7:2]] = v.mwd;
            @(posedge clk); #1;
        end
        sb.delete();

        // Reset one cycle after a granted DMA read discards the return
        cpu_read = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 1; dma_we = 0; dma_addr = 32'h4; dma_wdata = 0;
        #3;
        chk("rd_before_rst_gnt", {31'h0, dma_gnt}, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        cpu_read = 1; cpu_write = 1; cpu_addr = 32'h44; cpu_wdata = 32'h1234;
        dma_req = 1; dma_we = 1; dma_addr = 32'h48; dma_wdata = 32'h5;
        #3;
        chk_zero("rst_mid");
        @(posedge clk); #1;
        chk_zero("rst_hold");
        reset = 1'b0;
        cpu_read = 1; cpu_write = 0; cpu_addr = 32'h4;
        dma_req = 1; dma_we = 0; dma_addr = 32'h0;
        #3;
        chk("post_rst_rvalid", {31'h0, dma_rvalid}, 0);
        chk("post_rst_cpu_rdata", cpu_rdata, 0);
        chk("post_rst_gnt", {31'h0, dma_gnt}, 0);

        // Build up a partial starve count, then reset must clear it
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #4;
        @(posedge clk); #1;
        reset = 1'b0;
        found = -1;
        for (int k = 0; k < 20; k++) begin
            #3;
            if (dma_gnt) begin
                found = k;
                break;
            end
            @(posedge clk); #1;
        end
        chk("starve_after_reset_cycles", found, 8);
        chk("stall_at_forced_gnt", {31'h0, cpu_stall}, 1);
        @(posedge clk); #1;
        cpu_read = 0; dma_req = 0;
        #3;
        chk("forced_read_rvalid", {31'h0, dma_rvalid}, 1);
        chk("forced_read_rdata", dma_rdata, 32'h11);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
